// File: rtl/alligator_pkg.sv
// Shared definitions for the Alligator sliding-window averager.
//   - Window lengths for the three moving averages (blue/red/green).
//   - Circular buffer depth and pointer width.
//   - Controller state encoding.
//   - sum_width(): running-sum width needed to hold 13 x max price.
package alligator_pkg;

    localparam int W_BLUE    = 13;
    localparam int W_RED     = 8;
    localparam int W_GREEN   = 5;
    localparam int BUF_DEPTH = 16;
    localparam int PTR_W     = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UPDATE = 3'd1,
        DIV13  = 3'd2,
        DIV5   = 3'd3,
        OUT    = 3'd4
    } state_e;

    // 13 x (2^DATA_W - 1) < 2^(DATA_W+4), so four guard bits suffice.
    function automatic int sum_width(input int data_w);
        return data_w + 4;
    endfunction

endpackage

// File: rtl/alligator_sma_stream_divu.sv
// sma_divu: sequential restoring unsigned divider, SUM_W-bit dividend,
// 4-bit divisor, one quotient bit per cycle.
// Ports:
//   Clk, Rst      clock, asynchronous active-low reset (aborts a divide)
//   start         load dividend/divisor; first iteration happens on this edge
//   dividend      SUM_W-bit unsigned dividend
//   divisor       4-bit unsigned divisor (non-zero)
//   busy          a divide is in progress
//   done          one-cycle pulse; quotient is final while done is high and
//                 is meant to be captured on the edge that ends the pulse,
//                 SUM_W edges after the start edge
//   quotient      SUM_W-bit quotient
// A start while done is high begins a new divide back-to-back.
module sma_divu #(
    parameter int SUM_W = 36
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [3:0]       divisor,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    localparam int CNT_W = $clog2(SUM_W + 1);

    logic [3:0]       rem_q;
    logic [SUM_W-1:0] quo_q;
    logic [3:0]       div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [3:0]       src_rem;
    logic [SUM_W-1:0] src_quo;
    logic [3:0]       src_div;
    logic [4:0]       shifted;
    logic [3:0]       rem_nxt;
    logic [SUM_W-1:0] quo_nxt;

    // One restoring step. On start the step works on the fresh operands so
    // that SUM_W steps complete by the edge after the last done cycle.
    always_comb begin
        src_rem = start ? 4'd0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_div = start ? divisor : div_q;
        shifted = {src_rem, src_quo[SUM_W-1]};
        rem_nxt = shifted[3:0];
        quo_nxt = {src_quo[SUM_W-2:0], 1'b0};
        if (shifted >= {1'b0, src_div}) begin
            rem_nxt = 4'(shifted - {1'b0, src_div});
            quo_nxt = {src_quo[SUM_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= rem_nxt;
            quo_q  <= quo_nxt;
            div_q  <= divisor;
            cnt_q  <= CNT_W'(SUM_W - 1);
            busy_q <= 1'b1;
        end else if (busy_q && (cnt_q != '0)) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - 1'b1;
        end else if (busy_q) begin
            busy_q <= 1'b0;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == '0);
    assign quotient = quo_q;

endmodule

// File: rtl/alligator_sma_stream.sv
// alligator_sma_stream: streaming 13/8/5-sample simple moving averager.
// Accepts one unsigned price per handshake into a 16-entry circular buffer,
// keeps three running sums, and once 13 prices have been seen produces
// floor averages blue13/red8/green5 over a valid/ready output handshake.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid (sma_valid) holds its data stable until ready is seen,
// and price_ready is only high in IDLE.
// Ports:
//   Clk, Rst            clock, asynchronous active-low reset
//   price_valid/ready   input handshake, price_data = newest price
//   sma_valid/ready     output handshake for blue13/red8/green5
//   warm                13 or more prices accepted since reset
//   fsm_state           controller state (debug)
//   div_active          shared divider busy (debug)
module alligator_sma_stream
    import alligator_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SUM_W  = sum_width(DATA_W)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              price_valid,
    output logic              price_ready,
    input  logic [DATA_W-1:0] price_data,
    output logic              sma_valid,
    input  logic              sma_ready,
    output logic [DATA_W-1:0] blue13,
    output logic [DATA_W-1:0] red8,
    output logic [DATA_W-1:0] green5,
    output logic              warm,
    output state_e            fsm_state,
    output logic              div_active
);

    localparam logic [3:0] CNT_FULL = 4'(W_BLUE);

    state_e state, state_nxt;

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] price_q;
    logic [SUM_W-1:0]  sum13, sum8, sum5;
    logic [DATA_W-1:0] blue_q, red_q, green_q;

    logic              accept;
    logic [PTR_W-1:0]  idx13, idx8, idx5;
    logic [SUM_W-1:0]  old13, old8, old5;
    logic [SUM_W-1:0]  sum13_nxt, sum8_nxt, sum5_nxt;
    logic [3:0]        cnt_nxt;

    logic              div_start;
    logic [SUM_W-1:0]  div_dividend;
    logic [3:0]        div_divisor;
    logic              div_busy;
    logic              div_done;
    logic [SUM_W-1:0]  div_quotient;

    assign price_ready = (state == IDLE) && Rst;
    assign accept      = price_valid && price_ready;

    // In UPDATE wp already points one past the new sample, so the sample
    // leaving an N-window sits at wp - (N + 1).
    assign idx13 = wp - PTR_W'(W_BLUE + 1);
    assign idx8  = wp - PTR_W'(W_RED + 1);
    assign idx5  = wp - PTR_W'(W_GREEN + 1);

    // The buffer is never cleared, so the fill count decides whether an
    // outgoing sample exists; stale entries are never read.
    assign old13 = (cnt >= 4'(W_BLUE))  ? SUM_W'(mem[idx13]) : '0;
    assign old8  = (cnt >= 4'(W_RED))   ? SUM_W'(mem[idx8])  : '0;
    assign old5  = (cnt >= 4'(W_GREEN)) ? SUM_W'(mem[idx5])  : '0;

    assign sum13_nxt = sum13 + SUM_W'(price_q) - old13;
    assign sum8_nxt  = sum8  + SUM_W'(price_q) - old8;
    assign sum5_nxt  = sum5  + SUM_W'(price_q) - old5;
    assign cnt_nxt   = (cnt == CNT_FULL) ? CNT_FULL : cnt + 4'd1;

    always_comb begin
        state_nxt    = state;
        div_start    = 1'b0;
        div_dividend = sum13_nxt;
        div_divisor  = 4'(W_BLUE);
        case (state)
            IDLE: begin
                if (accept) state_nxt = UPDATE;
            end
            UPDATE: begin
                if (cnt_nxt == CNT_FULL) begin
                    state_nxt = DIV13;
                    div_start = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DIV13: begin
                // sum5 is already final here; chain the second divide.
                div_dividend = sum5;
                div_divisor  = 4'(W_GREEN);
                if (div_done) begin
                    state_nxt = DIV5;
                    div_start = 1'b1;
                end
            end
            DIV5: begin
                if (div_done) state_nxt = OUT;
            end
            OUT: begin
                if (sma_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (accept) mem[wp] <= price_data;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= IDLE;
            wp      <= '0;
            cnt     <= '0;
            price_q <= '0;
            sum13   <= '0;
            sum8    <= '0;
            sum5    <= '0;
            blue_q  <= '0;
            red_q   <= '0;
            green_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wp      <= wp + 1'b1;
                price_q <= price_data;
            end
            if (state == UPDATE) begin
                sum13 <= sum13_nxt;
                sum8  <= sum8_nxt;
                sum5  <= sum5_nxt;
                cnt   <= cnt_nxt;
            end
            if ((state == DIV13) && div_done) begin
                blue_q <= DATA_W'(div_quotient);
            end
            if ((state == DIV5) && div_done) begin
                green_q <= DATA_W'(div_quotient);
                red_q   <= DATA_W'(sum8 >> 3);
            end
        end
    end

    sma_divu #(
        .SUM_W (SUM_W)
    ) u_divu (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign sma_valid  = (state == OUT);
    assign blue13     = blue_q;
    assign red8       = red_q;
    assign green5     = green_q;
    assign warm       = (cnt == CNT_FULL);
    assign fsm_state  = state;
    assign div_active = div_busy;

endmodule

// File: tb/tb_alligator_sma_stream.sv
// Directed bench for alligator_sma_stream: reset, warm-up, sliding with
// pointer wrap, output backpressure, full-scale prices, reset mid-divide.
module tb_alligator_sma_stream;
    import alligator_pkg::*;

    localparam int DATA_W = 32;
    localparam int LAT    = 2 * sum_width(DATA_W) + 1;

    // ---------------- clock / reset ----------------
    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              price_valid = 1'b0;
    logic [DATA_W-1:0] price_data = '0;
    logic              sma_ready = 1'b0;
    logic              price_ready;
    logic              sma_valid;
    logic [DATA_W-1:0] blue13, red8, green5;
    logic              warm;
    state_e            fsm_state;
    logic              div_active;

    always #5 Clk = ~Clk;

    alligator_sma_stream #(.DATA_W(DATA_W)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .price_valid (price_valid),
        .price_ready (price_ready),
        .price_data  (price_data),
        .sma_valid   (sma_valid),
        .sma_ready   (sma_ready),
        .blue13      (blue13),
        .red8        (red8),
        .green5      (green5),
        .warm        (warm),
        .fsm_state   (fsm_state),
        .div_active  (div_active)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [3*DATA_W-1:0] exp_q[$];
    int unsigned hist[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Floor average of the newest n prices from the bench history.
    function automatic logic [DATA_W-1:0] model_avg(input int n);
        logic [63:0] s;
        s = 0;
        for (int i = 0; i < n; i++) s += 64'(hist[hist.size() - 1 - i]);
        return DATA_W'(s / 64'(n));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] p);
        int w;
        w = 0;
        while (!price_ready && w < 400) begin
            step();
            w++;
        end
        chk("price_ready_wait", 64'(w < 400), 64'd1);
        price_valid = 1'b1;
        price_data  = p;
        step();
        price_valid = 1'b0;
        hist.push_back(p);
    endtask

    task automatic send_warm(input logic [DATA_W-1:0] p);
        logic saw;
        saw = 1'b0;
        send(p);
        repeat (4) begin
            step();
            if (sma_valid) saw = 1'b1;
        end
        chk("warmup_no_output", 64'(saw), 64'd0);
    endtask

    task automatic send_out(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] e13,
                            input logic [DATA_W-1:0] e8, input logic [DATA_W-1:0] e5);
        int lat;
        logic [3*DATA_W-1:0] e;
        exp_q.push_back({e13, e8, e5});
        send(p);
        lat = 0;
        while (!sma_valid && lat < 200) begin
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'(LAT));
        e = exp_q.pop_front();
        chk("blue13", 64'(blue13), 64'(e[3*DATA_W-1:2*DATA_W]));
        chk("red8", 64'(red8), 64'(e[2*DATA_W-1:DATA_W]));
        chk("green5", 64'(green5), 64'(e[DATA_W-1:0]));
        chk("warm", 64'(warm), 64'd1);
        chk("ready_in_out", 64'(price_ready), 64'd0);
    endtask

    task automatic take();
        sma_ready = 1'b1;
        step();
        sma_ready = 1'b0;
        chk("valid_after_take", 64'(sma_valid), 64'd0);
        chk("ready_after_take", 64'(price_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic stable, ready_seen, left_out, saw;

        // Reset
        repeat (3) step();
        chk("rst_price_ready", 64'(price_ready), 64'd0);
        chk("rst_sma_valid", 64'(sma_valid), 64'd0);
        chk("rst_outputs", 64'({blue13 | red8 | green5}), 64'd0);
        chk("rst_warm", 64'(warm), 64'd0);
        Rst = 1'b1;
        step();
        chk("rel_price_ready", 64'(price_ready), 64'd1);
        chk("rel_sma_valid", 64'(sma_valid), 64'd0);

        // Warm-up 1..12, then 13 gives the first output
        for (int i = 1; i <= 12; i++) send_warm(DATA_W'(i));
        chk("warm_at_12", 64'(warm), 64'd0);
        send_out(32'd13, 32'd7, 32'd9, 32'd11);
        take();

        // Slide, wrapping wp twice by price 40
        send_out(32'd14, 32'd8, 32'd10, 32'd12);
        take();
        for (int i = 15; i <= 39; i++) begin
            hist.push_back(DATA_W'(i));
            send_out(DATA_W'(i), model_avg(13), model_avg(8), model_avg(5));
            void'(hist.pop_back());
            take();
        end
        send_out(32'd40, 32'd34, 32'd36, 32'd38);

        // Backpressure with a pending price
        price_valid = 1'b1;
        price_data  = 32'h999;
        stable = 1'b1;
        ready_seen = 1'b0;
        left_out = 1'b0;
        repeat (200) begin
            step();
            if (blue13 !== 32'd34 || red8 !== 32'd36 || green5 !== 32'd38 || !sma_valid)
                stable = 1'b0;
            if (price_ready) ready_seen = 1'b1;
            if (fsm_state != OUT) left_out = 1'b1;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        chk("bp_price_ready", 64'(ready_seen), 64'd0);
        chk("bp_state_held", 64'(left_out), 64'd0);
        price_valid = 1'b0;
        take();
        chk("bp_idle", 64'(fsm_state), 64'(IDLE));
        step();
        chk("bp_single_xfer", 64'(sma_valid), 64'd0);

        // Full-scale prices
        for (int i = 0; i < 12; i++) begin
            hist.push_back(32'hFFFF_FFFF);
            send_out(32'hFFFF_FFFF, model_avg(13), model_avg(8), model_avg(5));
            void'(hist.pop_back());
            take();
        end
        send_out(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        take();
        send_out(32'h0, 32'hEC4E_C4EB, 32'hDFFF_FFFF, 32'hCCCC_CCCC);
        take();

        // Reset in the middle of DIV13
        send(32'd5);
        repeat (10) step();
        chk("mid_div13", 64'(fsm_state), 64'(DIV13));
        #2;
        Rst = 1'b0;
        #1;
        chk("async_rst_outputs", 64'({blue13 | red8 | green5}), 64'd0);
        chk("async_rst_warm", 64'(warm), 64'd0);
        chk("async_rst_valid", 64'(sma_valid), 64'd0);
        chk("async_rst_ready", 64'(price_ready), 64'd0);
        step();
        step();
        Rst = 1'b1;
        step();
        chk("rel2_price_ready", 64'(price_ready), 64'd1);
        saw = 1'b0;
        repeat (100) begin
            step();
            if (sma_valid) saw = 1'b1;
        end
        chk("aborted_no_output", 64'(saw), 64'd0);

        // Re-warm; stale buffer contents must not leak in
        hist.delete();
        for (int i = 0; i < 12; i++) send_warm(32'd10000);
        chk("rewarm_warm_12", 64'(warm), 64'd0);
        send_out(32'd10000, 32'd10000, 32'd10000, 32'd10000);
        take();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
